// File: rtl/rename_flow_if.sv
// Bundle of decode, ROB, wakeup and dispatch signals for the rename stage.
// "slave" is the rename stage's view; "master" is the surrounding pipeline's view.
interface rename_flow_if #(
    parameter int MAX_OPERANDS = 3,
    parameter int ARN_BITS     = 5,
    parameter int PRN_BITS     = 6,
    parameter int FU_COUNT     = 4,
    parameter int INST_ID_BITS = 6
) ();
    localparam int M        = MAX_OPERANDS;
    localparam int FUC_BITS = $clog2(FU_COUNT);

    logic                                   in_valid;
    logic                                   in_ready;
    logic [31:0]                            in_raw_instr;
    logic [63:0]                            in_instr_pc;
    logic [FUC_BITS-1:0]                    in_fu_choice;
    logic [M-1:0]                           in_arn_input_valid;
    logic [M-1:0][ARN_BITS-1:0]             in_arn_input;
    logic [M-1:0]                           in_arn_output_valid;
    logic [M-1:0][ARN_BITS-1:0]             in_arn_output;

    logic                                   rob_alloc_ready;
    logic [INST_ID_BITS-1:0]                rob_inst_id;
    logic                                   rob_alloc_fire;
    logic [M-1:0]                           free_valid;
    logic [M-1:0][PRN_BITS-1:0]             free_prns;
    logic [M-1:0]                           commit_valid;
    logic [M-1:0][ARN_BITS-1:0]             commit_arn;
    logic [M-1:0][PRN_BITS-1:0]             commit_prn;

    logic [FU_COUNT-1:0][M-1:0]             set_prn_ready_valid;
    logic [FU_COUNT-1:0][M-1:0][PRN_BITS-1:0] set_prn_ready;
    logic                                   flush;

    logic                                   out_valid;
    logic                                   out_ready;
    logic [INST_ID_BITS-1:0]                out_inst_id;
    logic [31:0]                            out_raw_instr;
    logic [63:0]                            out_instr_pc;
    logic [FUC_BITS-1:0]                    out_fu_choice;
    logic [M-1:0]                           out_prn_input_valid;
    logic [M-1:0]                           out_prn_input_ready;
    logic [M-1:0][PRN_BITS-1:0]             out_prn_input;
    logic [M-1:0]                           out_prn_output_valid;
    logic [M-1:0][PRN_BITS-1:0]             out_prn_output;
    logic [M-1:0]                           out_old_prn_valid;
    logic [M-1:0][PRN_BITS-1:0]             out_old_prn;
    logic [M-1:0][ARN_BITS-1:0]             out_old_arn;

    modport slave (
        input  in_valid, in_raw_instr, in_instr_pc, in_fu_choice,
               in_arn_input_valid, in_arn_input, in_arn_output_valid, in_arn_output,
               rob_alloc_ready, rob_inst_id, free_valid, free_prns,
               commit_valid, commit_arn, commit_prn,
               set_prn_ready_valid, set_prn_ready, flush, out_ready,
        output in_ready, rob_alloc_fire, out_valid, out_inst_id, out_raw_instr,
               out_instr_pc, out_fu_choice, out_prn_input_valid, out_prn_input_ready,
               out_prn_input, out_prn_output_valid, out_prn_output,
               out_old_prn_valid, out_old_prn, out_old_arn
    );

    modport master (
        output in_valid, in_raw_instr, in_instr_pc, in_fu_choice,
               in_arn_input_valid, in_arn_input, in_arn_output_valid, in_arn_output,
               rob_alloc_ready, rob_inst_id, free_valid, free_prns,
               commit_valid, commit_arn, commit_prn,
               set_prn_ready_valid, set_prn_ready, flush, out_ready,
        input  in_ready, rob_alloc_fire, out_valid, out_inst_id, out_raw_instr,
               out_instr_pc, out_fu_choice, out_prn_input_valid, out_prn_input_ready,
               out_prn_input, out_prn_output_valid, out_prn_output,
               out_old_prn_valid, out_old_prn, out_old_arn
    );
endinterface

// File: rtl/rename_flow_stage.sv
// Register-rename stage: speculative/committed RATs, bit-vector free list and PRN
// ready table, with a back-pressurable output register that snoops wakeups.
module rename_flow_stage #(
    parameter int MAX_OPERANDS = 3,
    parameter int ARN_BITS     = 5,
    parameter int PRN_BITS     = 6,
    parameter int FU_COUNT     = 4,
    parameter int INST_ID_BITS = 6
) (
    input logic        clk,
    input logic        rst,
    rename_flow_if.slave bus
);
    localparam int M        = MAX_OPERANDS;
    localparam int NUM_ARN  = 2 ** ARN_BITS;
    localparam int NUM_PRN  = 2 ** PRN_BITS;
    localparam int CNT_BITS = PRN_BITS + 1;
    localparam int FUC_BITS = $clog2(FU_COUNT);
    localparam logic [NUM_PRN-1:0] RESET_FREE = {{(NUM_PRN - NUM_ARN){1'b1}}, {NUM_ARN{1'b0}}};

    logic [PRN_BITS-1:0] spec_rat_q   [NUM_ARN];
    logic [PRN_BITS-1:0] spec_rat_d   [NUM_ARN];
    logic [PRN_BITS-1:0] commit_rat_q [NUM_ARN];
    logic [PRN_BITS-1:0] commit_rat_d [NUM_ARN];
    logic [NUM_PRN-1:0]  free_mask_q, free_mask_d;
    logic [NUM_PRN-1:0]  ready_q, ready_d;

    logic                        out_valid_q;
    logic [INST_ID_BITS-1:0]     out_inst_id_q;
    logic [31:0]                 out_raw_instr_q;
    logic [63:0]                 out_instr_pc_q;
    logic [FUC_BITS-1:0]         out_fu_choice_q;
    logic [M-1:0]                out_src_valid_q, out_src_ready_q;
    logic [M-1:0][PRN_BITS-1:0]  out_src_prn_q;
    logic [M-1:0]                out_dst_valid_q;
    logic [M-1:0][PRN_BITS-1:0]  out_dst_prn_q, out_old_prn_q;
    logic [M-1:0][ARN_BITS-1:0]  out_old_arn_q;

    logic [CNT_BITS-1:0]         need, have;
    logic                        in_ready, fire;
    logic [NUM_PRN-1:0]          bcast_vec, alloc_mask;
    logic [M-1:0][PRN_BITS-1:0]  alloc_prn, src_prn, old_prn;
    logic [M-1:0]                src_rdy, held_rdy;

    always_comb begin
        need = '0;
        have = '0;
        for (int i = 0; i < M; i++) need = need + CNT_BITS'(bus.in_arn_output_valid[i]);
        for (int p = 0; p < NUM_PRN; p++) have = have + CNT_BITS'(free_mask_q[p]);
    end

    assign in_ready = !bus.flush && !rst && bus.rob_alloc_ready
                   && (!out_valid_q || bus.out_ready) && (have >= need);
    assign fire     = bus.in_valid && in_ready;

    // Every wakeup broadcast this cycle, decoded to a per-PRN vector.
    always_comb begin
        bcast_vec = '0;
        for (int f = 0; f < FU_COUNT; f++)
            for (int i = 0; i < M; i++)
                if (bus.set_prn_ready_valid[f][i]) bcast_vec[bus.set_prn_ready[f][i]] = 1'b1;
    end

    // Destinations claim the lowest free PRNs in slot order.
    always_comb begin : alloc
        logic [NUM_PRN-1:0] avail;
        logic               found;
        avail      = free_mask_q;
        alloc_mask = '0;
        alloc_prn  = '0;
        for (int i = 0; i < M; i++) begin
            found = 1'b0;
            for (int p = 0; p < NUM_PRN; p++) begin
                if (!found && avail[p]) begin
                    alloc_prn[i] = PRN_BITS'(p);
                    found        = 1'b1;
                end
            end
            if (bus.in_arn_output_valid[i] && found) begin
                avail[alloc_prn[i]]      = 1'b0;
                alloc_mask[alloc_prn[i]] = 1'b1;
            end
        end
    end

    // Lookups use the RAT as it stood before this instruction's own writes.
    for (genvar gi = 0; gi < M; gi++) begin : g_slot
        assign src_prn[gi]  = spec_rat_q[bus.in_arn_input[gi]];
        assign src_rdy[gi]  = ready_q[src_prn[gi]] | bcast_vec[src_prn[gi]];
        assign old_prn[gi]  = spec_rat_q[bus.in_arn_output[gi]];
        assign held_rdy[gi] = out_src_ready_q[gi] | bcast_vec[out_src_prn_q[gi]];
    end

    always_comb begin
        commit_rat_d = commit_rat_q;
        for (int i = 0; i < M; i++)
            if (bus.commit_valid[i]) commit_rat_d[bus.commit_arn[i]] = bus.commit_prn[i];
        spec_rat_d  = spec_rat_q;
        free_mask_d = free_mask_q;
        ready_d     = ready_q | bcast_vec;
        if (bus.flush) begin
            // Rebuild from the committed map; same-cycle frees are already covered.
            spec_rat_d  = commit_rat_d;
            free_mask_d = '1;
            for (int a = 0; a < NUM_ARN; a++) free_mask_d[commit_rat_d[a]] = 1'b0;
            ready_d     = '1;
        end else begin
            for (int i = 0; i < M; i++)
                if (bus.free_valid[i]) free_mask_d[bus.free_prns[i]] = 1'b1;
            if (fire) begin
                free_mask_d = free_mask_d & ~alloc_mask;
                ready_d     = ready_d & ~alloc_mask;
                for (int i = 0; i < M; i++)
                    if (bus.in_arn_output_valid[i]) spec_rat_d[bus.in_arn_output[i]] = alloc_prn[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int a = 0; a < NUM_ARN; a++) begin
                spec_rat_q[a]   <= PRN_BITS'(a);
                commit_rat_q[a] <= PRN_BITS'(a);
            end
            free_mask_q <= RESET_FREE;
            ready_q     <= '1;
        end else begin
            spec_rat_q   <= spec_rat_d;
            commit_rat_q <= commit_rat_d;
            free_mask_q  <= free_mask_d;
            ready_q      <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q     <= 1'b0;
            out_inst_id_q   <= '0;
            out_raw_instr_q <= '0;
            out_instr_pc_q  <= '0;
            out_fu_choice_q <= '0;
            out_src_valid_q <= '0;
            out_src_ready_q <= '0;
            out_src_prn_q   <= '0;
            out_dst_valid_q <= '0;
            out_dst_prn_q   <= '0;
            out_old_prn_q   <= '0;
            out_old_arn_q   <= '0;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (fire) begin
            out_valid_q     <= 1'b1;
            out_inst_id_q   <= bus.rob_inst_id;
            out_raw_instr_q <= bus.in_raw_instr;
            out_instr_pc_q  <= bus.in_instr_pc;
            out_fu_choice_q <= bus.in_fu_choice;
            out_src_valid_q <= bus.in_arn_input_valid;
            out_src_ready_q <= src_rdy;
            out_src_prn_q   <= src_prn;
            out_dst_valid_q <= bus.in_arn_output_valid;
            out_dst_prn_q   <= alloc_prn;
            out_old_prn_q   <= old_prn;
            out_old_arn_q   <= bus.in_arn_output;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end else if (out_valid_q) begin
            out_src_ready_q <= held_rdy;
        end
    end

    assign bus.in_ready             = in_ready;
    assign bus.rob_alloc_fire       = fire;
    assign bus.out_valid            = out_valid_q;
    assign bus.out_inst_id          = out_inst_id_q;
    assign bus.out_raw_instr        = out_raw_instr_q;
    assign bus.out_instr_pc         = out_instr_pc_q;
    assign bus.out_fu_choice        = out_fu_choice_q;
    assign bus.out_prn_input_valid  = out_src_valid_q;
    assign bus.out_prn_input_ready  = out_src_ready_q;
    assign bus.out_prn_input        = out_src_prn_q;
    assign bus.out_prn_output_valid = out_dst_valid_q;
    assign bus.out_prn_output       = out_dst_prn_q;
    assign bus.out_old_prn_valid    = out_dst_valid_q;
    assign bus.out_old_prn          = out_old_prn_q;
    assign bus.out_old_arn          = out_old_arn_q;
endmodule

// File: tb/tb_rename_flow_stage.sv
// Directed test of rename_flow_stage: renaming, wakeup bypass/snoop, free-list
// exhaustion and refill, flush rebuild, back-pressure and mid-run reset.
module tb_rename_flow_stage;
    localparam int M = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_fired;

    always #5 clk = ~clk;

    rename_flow_if #(.MAX_OPERANDS(3), .ARN_BITS(5), .PRN_BITS(6), .FU_COUNT(4), .INST_ID_BITS(6)) bus_if ();

    rename_flow_stage #(.MAX_OPERANDS(3), .ARN_BITS(5), .PRN_BITS(6), .FU_COUNT(4), .INST_ID_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Negative arguments leave a slot unused.
    task automatic set_instr(input int s0, input int s1, input int d0);
        bus_if.in_arn_input_valid  = '0;
        bus_if.in_arn_input        = '0;
        bus_if.in_arn_output_valid = '0;
        bus_if.in_arn_output       = '0;
        if (s0 >= 0) begin bus_if.in_arn_input_valid[0] = 1'b1; bus_if.in_arn_input[0] = 5'(s0); end
        if (s1 >= 0) begin bus_if.in_arn_input_valid[1] = 1'b1; bus_if.in_arn_input[1] = 5'(s1); end
        if (d0 >= 0) begin bus_if.in_arn_output_valid[0] = 1'b1; bus_if.in_arn_output[0] = 5'(d0); end
    endtask

    // One line per accepted instruction.
    always @(posedge clk) begin
        if (bus_if.rob_alloc_fire)
            $display("rename id=%0d dst_valid=%b dst0=x%0d src0=x%0d", bus_if.rob_inst_id,
                     bus_if.in_arn_output_valid, bus_if.in_arn_output[0], bus_if.in_arn_input[0]);
    end

    // Duplicate destination ARNs within one instruction are illegal stimulus.
    always @(posedge clk) begin
        if (!rst && bus_if.in_valid) begin
            for (int i = 0; i < M; i++)
                for (int j = i + 1; j < M; j++)
                    assert (!(bus_if.in_arn_output_valid[i] && bus_if.in_arn_output_valid[j]
                              && bus_if.in_arn_output[i] == bus_if.in_arn_output[j]))
                    else $error("duplicate destination ARN in one instruction");
        end
    end

    initial begin
        bus_if.in_valid            = 1'b0;
        bus_if.in_raw_instr        = '0;
        bus_if.in_instr_pc         = '0;
        bus_if.in_fu_choice        = '0;
        bus_if.rob_alloc_ready     = 1'b1;
        bus_if.rob_inst_id         = '0;
        bus_if.free_valid          = '0;
        bus_if.free_prns           = '0;
        bus_if.commit_valid        = '0;
        bus_if.commit_arn          = '0;
        bus_if.commit_prn          = '0;
        bus_if.set_prn_ready_valid = '0;
        bus_if.set_prn_ready       = '0;
        bus_if.flush               = 1'b0;
        bus_if.out_ready           = 1'b1;
        set_instr(-1, -1, -1);

        tick(); tick();
        rst = 1'b0;
        settle();
        check("reset_out_valid", bus_if.out_valid, 0);
        check("reset_out_prn_output", bus_if.out_prn_output[0], 0);
        check("reset_in_ready", bus_if.in_ready, 1);

        // x1 <- x2, x3
        set_instr(2, 3, 1);
        bus_if.in_valid     = 1'b1;
        bus_if.rob_inst_id  = 6'd5;
        bus_if.in_raw_instr = 32'hDEADBEEF;
        bus_if.in_instr_pc  = 64'h1000;
        bus_if.in_fu_choice = 2'd2;
        settle();
        check("t1_fire", bus_if.rob_alloc_fire, 1);
        check("t1_out_valid_before_edge", bus_if.out_valid, 0);
        tick();
        check("t1_out_valid", bus_if.out_valid, 1);
        check("t1_src0", bus_if.out_prn_input[0], 2);
        check("t1_src1", bus_if.out_prn_input[1], 3);
        check("t1_src_ready", bus_if.out_prn_input_ready[1:0], 2'b11);
        check("t1_dst", bus_if.out_prn_output[0], 32);
        check("t1_dst_valid", bus_if.out_prn_output_valid, 3'b001);
        check("t1_old_prn", bus_if.out_old_prn[0], 1);
        check("t1_old_arn", bus_if.out_old_arn[0], 1);
        check("t1_inst_id", bus_if.out_inst_id, 5);
        check("t1_raw", bus_if.out_raw_instr, 32'hDEADBEEF);
        check("t1_pc", bus_if.out_instr_pc, 64'h1000);
        check("t1_fu", bus_if.out_fu_choice, 2);

        // x4 <- x1 (x1 now lives in 32, not yet ready)
        set_instr(1, -1, 4);
        bus_if.rob_inst_id = 6'd6;
        tick();
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        settle();
        check("t2_src0", bus_if.out_prn_input[0], 32);
        check("t2_src0_ready", bus_if.out_prn_input_ready[0], 0);
        check("t2_dst", bus_if.out_prn_output[0], 33);
        tick();
        check("t2_hold_ready", bus_if.out_prn_input_ready[0], 0);
        bus_if.set_prn_ready_valid[2][1] = 1'b1;
        bus_if.set_prn_ready[2][1]       = 6'd32;
        tick();
        bus_if.set_prn_ready_valid = '0;
        check("t2_snoop_ready", bus_if.out_prn_input_ready[0], 1);
        check("t2_snoop_prn", bus_if.out_prn_input[0], 32);
        check("t2_snoop_valid", bus_if.out_valid, 1);

        // Reader of x4 (prn 33) with a same-cycle broadcast of 33
        bus_if.out_ready = 1'b1;
        set_instr(4, -1, -1);
        bus_if.in_valid = 1'b1;
        bus_if.set_prn_ready_valid[0][0] = 1'b1;
        bus_if.set_prn_ready[0][0]       = 6'd33;
        tick();
        bus_if.set_prn_ready_valid = '0;
        check("t3_bypass_prn", bus_if.out_prn_input[0], 33);
        check("t3_bypass_ready", bus_if.out_prn_input_ready[0], 1);
        tick();
        check("t3_table_ready", bus_if.out_prn_input_ready[0], 1);

        // Drain the free list with single-destination renames of x5 (34..63 remain)
        set_instr(-1, -1, 5);
        n_fired = 0;
        for (int k = 0; k < 40; k++) begin
            settle();
            if (bus_if.rob_alloc_fire) n_fired++;
            tick();
        end
        check("exhaust_fired", n_fired, 30);
        settle();
        check("exhaust_in_ready", bus_if.in_ready, 0);
        bus_if.free_valid[0] = 1'b1;
        bus_if.free_prns[0]  = 6'd1;
        settle();
        check("free_same_cycle_in_ready", bus_if.in_ready, 0);
        tick();
        bus_if.free_valid = '0;
        settle();
        check("free_next_in_ready", bus_if.in_ready, 1);
        tick();
        check("free_realloc_dst", bus_if.out_prn_output[0], 1);
        check("free_realloc_old", bus_if.out_old_prn[0], 63);
        bus_if.in_valid = 1'b0;

        // Flush with committed RAT still at identity
        set_instr(1, -1, -1);
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        bus_if.flush     = 1'b1;
        settle();
        check("flush_in_ready", bus_if.in_ready, 0);
        tick();
        bus_if.flush     = 1'b0;
        bus_if.out_ready = 1'b1;
        check("flush_out_valid", bus_if.out_valid, 0);
        set_instr(1, -1, 2);
        bus_if.in_valid = 1'b1;
        settle();
        check("flush_resume_in_ready", bus_if.in_ready, 1);
        tick();
        bus_if.in_valid = 1'b0;
        check("flush_src_x1", bus_if.out_prn_input[0], 1);
        check("flush_src_ready", bus_if.out_prn_input_ready[0], 1);
        check("flush_dst", bus_if.out_prn_output[0], 32);
        check("flush_old_prn", bus_if.out_old_prn[0], 2);

        // Flush with a same-cycle commit x7 -> 40
        bus_if.flush           = 1'b1;
        bus_if.commit_valid[0] = 1'b1;
        bus_if.commit_arn[0]   = 5'd7;
        bus_if.commit_prn[0]   = 6'd40;
        tick();
        bus_if.flush        = 1'b0;
        bus_if.commit_valid = '0;
        set_instr(7, -1, 3);
        bus_if.in_valid = 1'b1;
        tick();
        check("commit_src_x7", bus_if.out_prn_input[0], 40);
        check("commit_dst", bus_if.out_prn_output[0], 7);
        check("commit_old_prn", bus_if.out_old_prn[0], 3);

        // Back-pressure for 5 cycles with in_valid held
        bus_if.out_ready = 1'b0;
        set_instr(3, -1, 9);
        for (int k = 0; k < 5; k++) begin
            settle();
            check("stall_in_ready", bus_if.in_ready, 0);
            tick();
        end
        check("stall_dst_held", bus_if.out_prn_output[0], 7);
        check("stall_src_held", bus_if.out_prn_input[0], 40);
        check("stall_valid_held", bus_if.out_valid, 1);
        bus_if.out_ready = 1'b1;
        tick();
        check("stall_release_dst", bus_if.out_prn_output[0], 32);
        check("stall_release_src", bus_if.out_prn_input[0], 7);

        // Two destinations in slots 0 and 2
        set_instr(-1, -1, 10);
        bus_if.in_arn_output_valid[2] = 1'b1;
        bus_if.in_arn_output[2]       = 5'd11;
        tick();
        bus_if.in_valid = 1'b0;
        check("multi_dst_valid", bus_if.out_prn_output_valid, 3'b101);
        check("multi_dst0", bus_if.out_prn_output[0], 33);
        check("multi_dst2", bus_if.out_prn_output[2], 34);
        check("multi_old2", bus_if.out_old_prn[2], 11);

        // Reset mid-run
        rst = 1'b1;
        settle();
        check("rst_in_ready", bus_if.in_ready, 0);
        tick();
        rst = 1'b0;
        settle();
        check("rst_out_valid", bus_if.out_valid, 0);
        set_instr(10, -1, 1);
        bus_if.in_valid = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        check("rst_src_identity", bus_if.out_prn_input[0], 10);
        check("rst_dst", bus_if.out_prn_output[0], 32);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
